vga_frame_receiver: RTL

VGA_FRAME_RECEIVER -- requirements
Module: vga_frame_receiver

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_sync_edge.sv | 25 ++
 rtl/vga_frame_receiver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default VGA timing, counter widths, receiver state enum
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_TOTAL  = 800;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_TOTAL  = 525;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned PIX_X_W = 10;
  localparam int unsigned PIX_Y_W = 9;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  // Counters stick at all-ones so a runaway count still fails the next check.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - two-stage sync registering with falling-edge detect
module vga_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sync_i,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;

  // History resets high (sync idle level) so release from reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= sync_i;
      s2_q <= s1_q;
    end
  end

  assign fall_o = s2_q & ~s1_q;

endmodule

// File: rtl/vga_frame_receiver.sv
// rtl/vga_frame_receiver.sv - VGA timing checker and pixel coordinate recovery
module vga_frame_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL
) (
  input  logic               pix_clk,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [7:0]         input_vga_red,
  input  logic               input_data_valid,
  output logic [7:0]         output_vga_red,
  output logic               output_pixel_valid,
  output logic [PIX_X_W-1:0] pixel_x,
  output logic [PIX_Y_W-1:0] pixel_y,
  output logic               frame_start,
  output logic               frame_done,
  output logic               locked,
  output logic               timing_error
);

  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t H_LAST_C = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
  localparam cnt_t V_TOT_C  = cnt_t'(V_TOTAL);

  logic hs_fall;
  logic vs_fall;

  vga_sync_edge u_hsync_edge (
    .clk_i   (pix_clk),
    .reset_i (reset),
    .sync_i  (hsync),
    .fall_o  (hs_fall)
  );

  vga_sync_edge u_vsync_edge (
    .clk_i   (pix_clk),
    .reset_i (reset),
    .sync_i  (vsync),
    .fall_o  (vs_fall)
  );

  rx_state_e          state_q;
  logic [7:0]         red_s1_q;
  logic               valid_s1_q;
  cnt_t               lcnt_q, pcnt_q, acnt_q, hcnt_q;
  logic [7:0]         red_q;
  logic               pix_valid_q;
  logic [PIX_X_W-1:0] pix_x_q;
  logic [PIX_Y_W-1:0] pix_y_q;
  logic               frame_start_q, frame_done_q, locked_q, timing_error_q;

  cnt_t lcnt_d, pcnt_d, acnt_d, hcnt_d;
  cnt_t pc_base, ac_h, hc_h;
  logic checking, err;

  // hsync bookkeeping is applied before the vsync check so coincident edges see updated counts.
  always_comb begin
    checking = (state_q != ST_SEARCH);
    pc_base  = hs_fall ? '0 : pcnt_q;
    ac_h     = (hs_fall && (pcnt_q == H_ACT_C)) ? sat_inc(acnt_q) : acnt_q;
    hc_h     = hs_fall ? sat_inc(hcnt_q) : hcnt_q;
    acnt_d   = vs_fall ? '0 : ac_h;
    hcnt_d   = vs_fall ? '0 : hc_h;
    lcnt_d   = hs_fall ? '0 : sat_inc(lcnt_q);
    pcnt_d   = valid_s1_q ? sat_inc(pc_base) : pc_base;
    err      = checking && (
                 (hs_fall && (lcnt_q != H_LAST_C)) ||
                 (hs_fall && (pcnt_q != '0) && (pcnt_q != H_ACT_C)) ||
                 (valid_s1_q && (pc_base >= H_ACT_C)) ||
                 (vs_fall && ((ac_h != V_ACT_C) || (hc_h != V_TOT_C))));
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      state_q        <= ST_SEARCH;
      red_s1_q       <= '0;
      valid_s1_q     <= 1'b0;
      lcnt_q         <= '0;
      pcnt_q         <= '0;
      acnt_q         <= '0;
      hcnt_q         <= '0;
      red_q          <= '0;
      pix_valid_q    <= 1'b0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      locked_q       <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      red_s1_q       <= input_vga_red;
      valid_s1_q     <= input_data_valid;
      red_q          <= red_s1_q;
      pix_valid_q    <= checking && valid_s1_q;
      pix_x_q        <= pc_base;
      pix_y_q        <= acnt_d[PIX_Y_W-1:0];
      frame_start_q  <= checking && valid_s1_q && (pc_base == '0) && (acnt_d == '0);
      frame_done_q   <= checking && vs_fall && !err;
      timing_error_q <= err;
      if (err) begin
        lcnt_q   <= '0;
        pcnt_q   <= '0;
        acnt_q   <= '0;
        hcnt_q   <= '0;
        locked_q <= 1'b0;
        state_q  <= ST_SEARCH;
      end else begin
        lcnt_q <= lcnt_d;
        pcnt_q <= pcnt_d;
        acnt_q <= acnt_d;
        hcnt_q <= hcnt_d;
        case (state_q)
          ST_SEARCH: if (vs_fall) state_q <= ST_CHECK;
          ST_CHECK: begin
            if (vs_fall) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end
          end
          ST_LOCKED: locked_q <= 1'b1;
          default: begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign output_vga_red     = red_q;
  assign output_pixel_valid = pix_valid_q;
  assign pixel_x            = pix_x_q;
  assign pixel_y            = pix_y_q;
  assign frame_start        = frame_start_q;
  assign frame_done         = frame_done_q;
  assign locked             = locked_q;
  assign timing_error       = timing_error_q;

endmodule
